// File: rtl/exp3_pkg.sv
// Shared constants for the Exp3 memory-game datapath: widths and the ROM
// sequence the player must reproduce.
package exp3_pkg;

  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 4;
  localparam int ROM_DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Packed with entry 15 leftmost so ROM_INIT[a] yields the word at address a.
  localparam logic [ROM_DEPTH-1:0][DATA_W-1:0] ROM_INIT = {
    4'b0100, 4'b0001, 4'b1000, 4'b1000,   // 15..12
    4'b0100, 4'b0100, 4'b0010, 4'b0010,   // 11..8
    4'b0001, 4'b0001, 4'b0010, 4'b0100,   //  7..4
    4'b1000, 4'b0100, 4'b0010, 4'b0001    //  3..0
  };

endpackage

// File: rtl/rom_16x4.sv
// Combinational 16x4 ROM holding the game sequence from ROM_INIT.
module rom_16x4
  import exp3_pkg::*;
(
  input  logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] saida
);

  assign saida = ROM_INIT[endereco];

endmodule

// File: rtl/exp3_fluxo_dados.sv
// Exp3 datapath: address counter into the sequence ROM, switch register and
// comparator. Define EXP3_COMPARE_MAGNITUDE_EN to add greater/less-than flags.
module exp3_fluxo_dados
  import exp3_pkg::*;
(
  input  logic              clock,
  input  logic              zeraC,
  input  logic              zeraR,
  input  logic              contaC,
  input  logic              registraR,
  input  logic [DATA_W-1:0] chaves,
  output logic              chavesIgualMemoria,
`ifdef EXP3_COMPARE_MAGNITUDE_EN
  output logic              chavesMaiorMemoria,
  output logic              chavesMenorMemoria,
`endif
  output logic              fimC,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [DATA_W-1:0] db_chaves,
  output logic [DATA_W-1:0] db_memoria
);

  addr_t contagem;
  word_t registro;
  word_t memoria;

  // Each reset clears only its own element, so the controller can restart
  // the sequence without losing the last switch entry.
  always_ff @(posedge clock or posedge zeraC) begin
    if (zeraC)       contagem <= '0;
    else if (contaC) contagem <= contagem + 1'b1;
  end

  always_ff @(posedge clock or posedge zeraR) begin
    if (zeraR)          registro <= '0;
    else if (registraR) registro <= chaves;
  end

  rom_16x4 uRom (
    .endereco (contagem),
    .saida    (memoria)
  );

  assign chavesIgualMemoria = (registro == memoria);
`ifdef EXP3_COMPARE_MAGNITUDE_EN
  assign chavesMaiorMemoria = (registro > memoria);
  assign chavesMenorMemoria = (registro < memoria);
`endif

  assign fimC        = (contagem == addr_t'(ROM_DEPTH - 1));
  assign db_contagem = contagem;
  assign db_chaves   = registro;
  assign db_memoria  = memoria;

endmodule

// File: tb/tb_exp3_fluxo_dados.sv
// Scoreboard bench for exp3_fluxo_dados: directed game steps then random
// enable/reset traffic against a plain arithmetic reference model.
module tb_exp3_fluxo_dados;

  logic       clock = 1'b0;
  logic       zeraC = 1'b0, zeraR = 1'b0, contaC = 1'b0, registraR = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic       chavesIgualMemoria, fimC;
  logic [3:0] db_contagem, db_chaves, db_memoria;
`ifdef EXP3_COMPARE_MAGNITUDE_EN
  logic       chavesMaiorMemoria, chavesMenorMemoria;
`endif

  exp3_fluxo_dados dut (
    .clock              (clock),
    .zeraC              (zeraC),
    .zeraR              (zeraR),
    .contaC             (contaC),
    .registraR          (registraR),
    .chaves             (chaves),
    .chavesIgualMemoria (chavesIgualMemoria),
`ifdef EXP3_COMPARE_MAGNITUDE_EN
    .chavesMaiorMemoria (chavesMaiorMemoria),
    .chavesMenorMemoria (chavesMenorMemoria),
`endif
    .fimC               (fimC),
    .db_contagem        (db_contagem),
    .db_chaves          (db_chaves),
    .db_memoria         (db_memoria)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [3:0] cnt, rg, mem;
    logic       ig, fim, gt, lt;
  } exp_t;

  exp_t q[$];
  int   nChk = 0, nFail = 0;
  event asyncChk;

  int romSeq [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};
  int mCnt = 0, mReg = 0;

  function automatic exp_t model(string tag);
    exp_t e;
    int   w;
    w     = romSeq[mCnt];
    e.tag = tag;
    e.cnt = 4'(mCnt);
    e.rg  = 4'(mReg);
    e.mem = 4'(w);
    e.ig  = (mReg == w);
    e.gt  = (mReg > w);
    e.lt  = (mReg < w);
    e.fim = (mCnt == 15);
    return e;
  endfunction

  task automatic chk(string name, string tag, logic [3:0] act, logic [3:0] req);
    nChk++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s.%s actual=%h required=%h t=%0t", tag, name, act, req, $time);
    end
  endtask

  // Monitor: compares every queued expectation when outputs are sampled.
  initial forever begin
    @(negedge clock or asyncChk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("contagem", e.tag, db_contagem, e.cnt);
      chk("chaves",   e.tag, db_chaves,   e.rg);
      chk("memoria",  e.tag, db_memoria,  e.mem);
      chk("igual",    e.tag, {3'b0, chavesIgualMemoria}, {3'b0, e.ig});
      chk("fimC",     e.tag, {3'b0, fimC}, {3'b0, e.fim});
`ifdef EXP3_COMPARE_MAGNITUDE_EN
      chk("maior",    e.tag, {3'b0, chavesMaiorMemoria}, {3'b0, e.gt});
      chk("menor",    e.tag, {3'b0, chavesMenorMemoria}, {3'b0, e.lt});
`endif
    end
  end

  // One clock cycle of stimulus; expectation is pushed right after the edge.
  task automatic cyc(string tag, logic zC, logic zR, logic cC, logic rR, logic [3:0] ch);
    @(negedge clock); #1;
    zeraC = zC; zeraR = zR; contaC = cC; registraR = rR; chaves = ch;
    @(posedge clock);
    if (zC)      mCnt = 0;
    else if (cC) mCnt = (mCnt + 1) % 16;
    if (zR)      mReg = 0;
    else if (rR) mReg = int'(ch);
    q.push_back(model(tag));
  endtask

  initial begin
    // 1: reset pulse
    cyc("reset", 1, 1, 0, 0, 4'h0);
    // 2: switches change without load
    cyc("noload", 0, 0, 0, 0, 4'h1);
    // 3: load, advance, load again
    cyc("load1", 0, 0, 0, 1, 4'h1);
    cyc("adv1",  0, 0, 1, 0, 4'h1);
    cyc("load2", 0, 0, 0, 1, 4'h2);
    // 4: mismatch at address 2
    cyc("adv2",  0, 0, 1, 0, 4'h2);
    cyc("load8", 0, 0, 0, 1, 4'h8);
    // 5: run to terminal count and wrap
    for (int i = 0; i < 13; i++) begin
      cyc("run", 0, 0, 1, 0, 4'h0);
      cyc("idle", 0, 0, 0, 0, 4'h0);
    end
    cyc("wrap", 0, 0, 1, 0, 4'h0);
    // 6: asynchronous counter clear between edges with contaC high
    cyc("pre6a", 0, 0, 1, 0, 4'h0);
    cyc("pre6b", 0, 0, 1, 1, 4'h5);
    @(negedge clock); #2;
    contaC = 1'b1; registraR = 1'b0;
    #1 zeraC = 1'b1;
    #1 mCnt = 0;
    q.push_back(model("asyncC"));
    -> asyncChk;
    @(posedge clock);
    q.push_back(model("holdC"));
    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(15) == 0), ($urandom_range(15) == 0),
          1'($urandom), 1'($urandom), 4'($urandom));
    end
    cyc("drain", 0, 0, 0, 0, 4'h0);
    repeat (2) @(negedge clock);
    nChk++;
    if (q.size() != 0) begin
      nFail++;
      $display("FAIL drain actual=%0d required=0 pending", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
